mul_share_arbiter: RTL and testbench



---
 rtl/mul_share_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin front end that lets NUM_REQ issue ports share
// one sequential 32x32 signed multiplier and returns the 64-bit product on a
// single tagged response channel.
// Build option: MUL_ZERO_BYPASS_EN -- when defined, an operation with a zero
// operand skips the multiplier and answers 0 directly.
//
// state | meaning
// IDLE  | waiting for a request; grants one lane combinationally
// ISSUE | mul_start pulse with operands stable
// WAIT  | multiplier running; capture product on mul_done
// RESP  | response presented until the consumer accepts it
module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [63:0]          rsp_product,
  output logic                 busy,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output logic                 mul_start,
  input  logic [63:0]          mul_product,
  input  logic                 mul_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] id;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  logic            grant;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic            zero_op;

  // Round-robin search: lanes at or above ptr win first, then wrap to lane 0.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && req_valid[i] && (ID_W'(i) >= ptr)) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(i);
      end
    end
  end

  // Operand mux for the candidate lane and the one-hot accept strobe.
  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        sel_a        = req_a[i*32 +: 32];
        sel_b        = req_b[i*32 +: 32];
        req_ready[i] = grant;
      end
    end
  end

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (sel_a == 32'd0) || (sel_b == 32'd0);
`else
  assign zero_op = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    mul_start = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy  = 1'b0;
        grant = gnt_any;
        if (gnt_any) begin
          state_nxt = zero_op ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand, tag, pointer and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a       <= '0;
      mul_b       <= '0;
      id          <= '0;
      ptr         <= '0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      if (grant) begin
        mul_a <= sel_a;
        mul_b <= sel_b;
        id    <= gnt_id;
        ptr   <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        if (zero_op) begin
          rsp_product <= '0;
          rsp_id      <= gnt_id;
        end
      end
      if ((state == S_WAIT) && mul_done) begin
        rsp_product <= mul_product;
        rsp_id      <= id;
      end
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: behavioural multiplier, scoreboard on the
// response channel, directed checks for latency, fairness, backpressure,
// reset abort and the zero-operand bypass.
module tb_mul_share_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam int DONE_DLY = 5;
`ifdef MUL_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [63:0]           rsp_product;
  logic                  busy;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic                  mul_start;
  logic [63:0]           mul_product;
  logic                  mul_done;

  int n_checks = 0;
  int n_fails  = 0;
  int n_start  = 0;
  int cyc      = 0;

  int          exp_id_q[$];
  logic [63:0] exp_p_q[$];
  int          grant_log[$];
  int          acc_cyc[$];

  always #5 clk = ~clk;

  mul_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product),
    .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_product(mul_product), .mul_done(mul_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Multiplier model: done pulses DONE_DLY cycles after the start cycle;
  // product bus carries junk except in the done cycle.
  logic [3:0]         mcnt;
  logic signed [63:0] mres;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mcnt        <= '0;
      mul_done    <= 1'b0;
      mul_product <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else begin
      mul_done    <= 1'b0;
      mul_product <= 64'hDEAD_BEEF_DEAD_BEEF;
      if (mul_start) begin
        mcnt <= 4'(DONE_DLY - 1);
        mres <= $signed(mul_a) * $signed(mul_b);
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 4'd1;
        if (mcnt == 4'd1) begin
          mul_done    <= 1'b1;
          mul_product <= mres;
        end
      end
    end
  end

  // Scoreboard: push on acceptance, pop and compare on response handshake.
  logic signed [31:0] la, lb;
  logic signed [63:0] xa, xb;
  always @(negedge clk) begin
    if (rst) begin
      exp_id_q.delete();
      exp_p_q.delete();
    end else begin
      if (mul_start) n_start++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          la = req_a[i*32 +: 32];
          lb = req_b[i*32 +: 32];
          xa = la;
          xb = lb;
          exp_id_q.push_back(i);
          exp_p_q.push_back(xa * xb);
          grant_log.push_back(i);
          acc_cyc.push_back(cyc);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_p_q.size() == 0) begin
          check("sb_unexpected_rsp", 64'd1, 64'd0);
        end else begin
          check("sb_id", 64'(rsp_id), 64'(exp_id_q.pop_front()));
          check("sb_product", rsp_product, exp_p_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (!busy && exp_p_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  // Present one request and hold it until accepted; returns in the cycle after acceptance.
  task automatic issue(input int lane, input logic [31:0] a, input logic [31:0] b);
    bit got = 1'b0;
    req_a[lane*32 +: 32] = a;
    req_b[lane*32 +: 32] = b;
    req_valid[lane]      = 1'b1;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (req_ready[lane]) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("grant_seen", 64'(got), 64'd1);
    check("grant_onehot", 64'(req_ready), 64'd1 << lane);
    tick();
    req_valid[lane] = 1'b0;
    #1;
    check("ready_pulse", 64'(req_ready), 64'd0);
  endtask

  task automatic run_op(input int lane, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit byp);
    int w = 0;
    bit prev_done = 1'b0;
    bit seen = 1'b0;
    issue(lane, a, b);
    check("start_in_issue", 64'(mul_start), 64'(!byp));
    for (int n = 0; n < 200; n++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      prev_done = mul_done;
      w++;
      tick();
    end
    check("rsp_seen", 64'(seen), 64'd1);
    check("rsp_latency", 64'(w), byp ? 64'd0 : 64'(DONE_DLY + 1));
    if (!byp) check("rsp_after_done", 64'(prev_done), 64'd1);
    check("rsp_product", rsp_product, exp);
    check("rsp_id", 64'(rsp_id), 64'(lane));
    tick();
    check("idle_after_rsp", 64'(busy), 64'd0);
  endtask

  initial begin
    int s0;
    int base;
    int acc;
    bit seen;
    bit bad;

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_product", rsp_product, 64'd0);
    check("rst_mul_start", 64'(mul_start), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();

    // Single op on lane 0.
    s0 = n_start;
    run_op(0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    check("single_mul_a", 64'(mul_a), 64'd7);
    check("single_mul_b", 64'(mul_b), 64'hFFFF_FFFD);
    check("single_start_count", 64'(n_start - s0), 64'd1);

    // Corner operands.
    run_op(2, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    run_op(2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1'b0);

    // Round-robin fairness from a fresh pointer.
    reset_dut();
    tick();
    base = grant_log.size();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*32 +: 32] = 32'((i + 1) * 1000 + 3);
      req_b[i*32 +: 32] = -32'((i + 2) * 17);
    end
    req_valid = '1;
    acc = 0;
    for (int n = 0; n < 400 && acc < 6; n++) begin
      #1;
      if (|(req_valid & req_ready)) acc++;
      tick();
    end
    req_valid = '0;
    wait_idle("rr_drain");
    check("rr_count", 64'(acc), 64'd6);
    check("rr_log_size", 64'(grant_log.size() - base), 64'd6);
    for (int k = 0; k < 6 && base + k < grant_log.size(); k++) begin
      check($sformatf("rr_order%0d", k), 64'(grant_log[base + k]), 64'(k % NUM_REQ));
      if (k > 0)
        check($sformatf("rr_gap%0d", k), 64'(acc_cyc[base + k] - acc_cyc[base + k - 1]),
              64'(DONE_DLY + 3));
    end

    // Backpressure: response held while another lane waits.
    rsp_ready = 1'b0;
    issue(0, 32'd11, 32'd13);
    req_a[32 +: 32] = 32'd21;
    req_b[32 +: 32] = 32'hFFFF_FFFE;
    req_valid[1]    = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("bp_rsp_seen", 64'(seen), 64'd1);
    for (int n = 0; n < 10; n++) begin
      #1;
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_product", rsp_product, 64'd143);
      check("bp_id", 64'(rsp_id), 64'd0);
      check("bp_no_grant", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    check("bp_regrant", 64'(req_ready), 64'd2);
    tick();
    req_valid[1] = 1'b0;
    wait_idle("bp_drain");

    // Reset while the multiplier is running.
    issue(3, 32'd9, 32'd9);
    tick();
    check("abort_in_wait", 64'(busy & ~mul_start & ~rsp_valid), 64'd1);
    rst = 1'b1;
    tick();
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_rsp_id", 64'(rsp_id), 64'd0);
    check("abort_rsp_product", rsp_product, 64'd0);
    check("abort_mul_a", 64'(mul_a), 64'd0);
    check("abort_mul_b", 64'(mul_b), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (rsp_valid || busy) bad = 1'b1;
      tick();
    end
    check("abort_quiet", 64'(bad), 64'd0);
    run_op(1, 32'd5, 32'd6, 64'd30, 1'b0);

    // Zero operand: bypassed or multiplied depending on build.
    s0 = n_start;
    run_op(3, 32'd0, 32'd123, 64'd0, BYPASS);
    check("zero_start_count", 64'(n_start - s0), BYPASS ? 64'd0 : 64'd1);

    wait_idle("final_drain");
    check("sb_empty", 64'(exp_p_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
